icache_direct: RTL and testbench
================================

// Module: icache_direct
// PURPOSE
//  Direct-mapped, one-word-per-line instruction cache between the instruction fetcher and the memory controller's fetch port.
//  - Hits return the instruction one cycle after the request.
//  - Misses issue a single 4-byte fetch to the memory controller, fill the line, then return the word.
//  - Drops the outstanding miss on in_rollback; cache contents survive rollback.
// PARAMETERS
//  INDEX_WIDTH  8  log2(line count); index = addr[INDEX_WIDTH+1:2], tag = addr[31:INDEX_WIDTH+2]
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, synchronous, active-high
//  rdy            in   1   global enable; low = freeze
//  in_rollback    in   1   misbranch flush
//  in_fetch_ena   in   1   fetcher request strobe (one outstanding max)
//  in_fetch_addr  in   32  instruction address (bits [1:0] ignored)
//  out_fetch_ok   out  1   one-cycle pulse, out_fetch_inst valid
//  out_fetch_inst out  32  returned instruction
//  out_mem_ena    out  1   one-cycle fetch request to memory controller
//  out_mem_addr   out  32  word-aligned fetch address
//  in_mem_ok      in   1   memory controller fetch done
//  in_mem_data    in   32  fetched word, little-endian, valid with in_mem_ok
// BEHAVIOUR
//  - Storage: valid[2^IW], tag[2^IW], data[2^IW] as register arrays, combinational read, write on fill.
//  - Reset: all valid<=0; state IDLE; out_fetch_ok=0, out_mem_ena=0, out_fetch_inst=0, out_mem_addr=0.
//  - Priority: rst > in_rollback > rdy. While rdy=0 (and no rollback), all registers, including pulse outputs, hold.
//  - Defaults: out_fetch_ok and out_mem_ena are cleared every enabled cycle unless set below.
//  - IDLE, in_fetch_ena=1:
//    - Hit (valid & tag match): out_fetch_ok<=1, out_fetch_inst<=data[idx] (latency 1).
//    - Miss: out_mem_ena<=1, out_mem_addr<={addr[31:2],2'b00}, latch addr -> WAIT_MEM.
//  - WAIT_MEM:
//    - in_fetch_ena is ignored (fetcher contract).
//    - On in_mem_ok: valid/tag/data[idx] <= 1/tag/in_mem_data; out_fetch_ok<=1, out_fetch_inst<=in_mem_data -> IDLE.
//  - Total miss latency is 1 + memory latency + 1 cycles.
//  - New request in the same cycle out_fetch_ok is high is legal and accepted in IDLE.
//  - in_rollback (any state, regardless of rdy):
//    - state<=IDLE, out_fetch_ok<=0, out_mem_ena<=0.
//    - in_fetch_ena and in_mem_ok in that cycle are discarded; no fill.
//    - Memory controller drops its pending fetch on the same signal, so no stale in_mem_ok arrives.
//  - in_mem_ok arriving in IDLE (not expected) is ignored, no fill.
//  - Index/tag use fixed widths; no wrap issues. Address 0xFFFF_FFFC is a normal line.
// CONFIGURATION
//  ICACHE_STATS_EN defined:
//    - Adds out_hit_cnt[31:0] and out_miss_cnt[31:0] output ports, reset to 0.
//    - Each counter increments once per IDLE lookup with rdy=1 and no rollback; wraps at 2^32.
//    - A rolled-back miss still counts as a miss.
//  ICACHE_STATS_EN undefined: ports and counters are absent; behaviour otherwise identical.
// TESTING
//  1. Cold miss: fetch 0x0000_0010 -> out_mem_ena pulse next cycle with addr 0x10.
//     in_mem_ok with data 0x00A00093 -> out_fetch_ok next cycle, inst 0x00A00093.
//  2. Re-fetch 0x10 -> out_fetch_ok 1 cycle later, inst 0x00A00093, out_mem_ena stays 0.
//  3. Conflict (IW=8): fetch 0x410 evicts 0x10 (miss, data 0x12345678); fetch 0x10 -> miss again.
//  4. Rollback in WAIT_MEM, with in_mem_ok in the same cycle -> no out_fetch_ok, line not filled.
//     Next fetch to the same address misses.
//  5. rdy=0 for 3 cycles while out_fetch_ok=1 -> ok and inst held; after rdy=1, ok clears next cycle.
//  6. Back-to-back hits 0x10 then 0x14 (both filled) -> ok pulses on consecutive cycles.
//     With ICACHE_STATS_EN, hit counter +2.

Source files
------------

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache between the fetcher and the memory fetch port.
// Optional hit/miss counters are compiled in with `define ICACHE_STATS_EN.
module icache_direct #(
    parameter int INDEX_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        in_rollback,
    input  logic        in_fetch_ena,
    input  logic [31:0] in_fetch_addr,
    output logic        out_fetch_ok,
    output logic [31:0] out_fetch_inst,
    output logic        out_mem_ena,
    output logic [31:0] out_mem_addr,
    input  logic        in_mem_ok,
    input  logic [31:0] in_mem_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] out_hit_cnt,
    output logic [31:0] out_miss_cnt
`endif
);

    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int TAG_W = 30 - INDEX_WIDTH;

    typedef enum logic {
        S_IDLE,
        S_WAIT_MEM
    } state_t;

    state_t                   state_q;
    logic [LINES-1:0]         valid_q;
    logic [TAG_W-1:0]         tag_q  [LINES];
    logic [31:0]              data_q [LINES];
    logic                     ok_q;
    logic [31:0]              inst_q;
    logic                     mem_ena_q;
    logic [31:0]              mem_addr_q;
    logic [29:0]              miss_addr_q;
`ifdef ICACHE_STATS_EN
    logic [31:0]              hit_cnt_q;
    logic [31:0]              miss_cnt_q;
`endif

    logic [INDEX_WIDTH-1:0]   req_idx;
    logic [TAG_W-1:0]         req_tag;
    logic                     lookup_hit;
    logic [INDEX_WIDTH-1:0]   fill_idx;
    logic [TAG_W-1:0]         fill_tag;
    logic                     fill_en;
    logic                     unused_addr_lsbs;

    assign req_idx          = in_fetch_addr[INDEX_WIDTH+1:2];
    assign req_tag          = in_fetch_addr[31:INDEX_WIDTH+2];
    assign lookup_hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign unused_addr_lsbs = ^in_fetch_addr[1:0];

    // The line being filled comes from the latched miss address, not the live request bus.
    assign fill_idx = miss_addr_q[INDEX_WIDTH-1:0];
    assign fill_tag = miss_addr_q[29:INDEX_WIDTH];
    assign fill_en  = !rst && !in_rollback && rdy && (state_q == S_WAIT_MEM) && in_mem_ok;

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= in_mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            ok_q       <= 1'b0;
            inst_q     <= '0;
            mem_ena_q  <= 1'b0;
            mem_addr_q <= '0;
`ifdef ICACHE_STATS_EN
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
`endif
        end else if (in_rollback) begin
            // Flush overrides the freeze; cache contents are kept.
            state_q   <= S_IDLE;
            ok_q      <= 1'b0;
            mem_ena_q <= 1'b0;
        end else if (rdy) begin
            ok_q      <= 1'b0;
            mem_ena_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_fetch_ena) begin
                        if (lookup_hit) begin
                            ok_q   <= 1'b1;
                            inst_q <= data_q[req_idx];
`ifdef ICACHE_STATS_EN
                            hit_cnt_q <= hit_cnt_q + 32'd1;
`endif
                        end else begin
                            mem_ena_q   <= 1'b1;
                            mem_addr_q  <= {in_fetch_addr[31:2], 2'b00};
                            miss_addr_q <= in_fetch_addr[31:2];
                            state_q     <= S_WAIT_MEM;
`ifdef ICACHE_STATS_EN
                            miss_cnt_q <= miss_cnt_q + 32'd1;
`endif
                        end
                    end
                end
                S_WAIT_MEM: begin
                    if (in_mem_ok) begin
                        valid_q[fill_idx] <= 1'b1;
                        ok_q              <= 1'b1;
                        inst_q            <= in_mem_data;
                        state_q           <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_fetch_ok   = ok_q;
    assign out_fetch_inst = inst_q;
    assign out_mem_ena    = mem_ena_q;
    assign out_mem_addr   = mem_addr_q;
`ifdef ICACHE_STATS_EN
    assign out_hit_cnt    = hit_cnt_q;
    assign out_miss_cnt   = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: vector table of fetches plus hand-written rollback, freeze and back-to-back sequences.
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        in_rollback;
    logic        in_fetch_ena;
    logic [31:0] in_fetch_addr;
    logic        out_fetch_ok;
    logic [31:0] out_fetch_inst;
    logic        out_mem_ena;
    logic [31:0] out_mem_addr;
    logic        in_mem_ok;
    logic [31:0] in_mem_data;
`ifdef ICACHE_STATS_EN
    logic [31:0] out_hit_cnt;
    logic [31:0] out_miss_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    icache_direct #(.INDEX_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .in_rollback   (in_rollback),
        .in_fetch_ena  (in_fetch_ena),
        .in_fetch_addr (in_fetch_addr),
        .out_fetch_ok  (out_fetch_ok),
        .out_fetch_inst(out_fetch_inst),
        .out_mem_ena   (out_mem_ena),
        .out_mem_addr  (out_mem_addr),
        .in_mem_ok     (in_mem_ok),
        .in_mem_data   (in_mem_data)
`ifdef ICACHE_STATS_EN
        ,
        .out_hit_cnt   (out_hit_cnt),
        .out_miss_cnt  (out_miss_cnt)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          hit;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_chk(input string name);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %h expected <none queued>", name, out_fetch_inst);
        end else begin
            chk(name, out_fetch_inst, sb_q.pop_front());
        end
    endtask

    // One request; on a miss the memory answers after lat cycles with data.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input bit hit, input int lat);
        @(negedge clk);
        in_fetch_ena  = 1'b1;
        in_fetch_addr = addr;
        sb_q.push_back(data);
        @(negedge clk);
        in_fetch_ena = 1'b0;
        chk("mem_ena", 32'(out_mem_ena), 32'(!hit));
        if (hit) begin
            chk("ok_hit", 32'(out_fetch_ok), 32'd1);
            pop_chk("inst_hit");
        end else begin
            chk("mem_addr", out_mem_addr, addr & 32'hFFFF_FFFC);
            chk("ok_miss_req", 32'(out_fetch_ok), 32'd0);
            for (int k = 1; k < lat; k++) begin
                @(negedge clk);
                chk("ok_wait", 32'(out_fetch_ok), 32'd0);
            end
            in_mem_ok   = 1'b1;
            in_mem_data = data;
            @(negedge clk);
            in_mem_ok   = 1'b0;
            in_mem_data = '0;
            chk("ok_fill", 32'(out_fetch_ok), 32'd1);
            pop_chk("inst_fill");
        end
    endtask

    initial begin
        logic [31:0] h0;
        vecs[0]  = '{32'h0000_0010, 32'h00A0_0093, 1'b0, 1};
        vecs[1]  = '{32'h0000_0010, 32'h00A0_0093, 1'b1, 1};
        vecs[2]  = '{32'h0000_0014, 32'h1111_1111, 1'b0, 2};
        vecs[3]  = '{32'h0000_0410, 32'h1234_5678, 1'b0, 3};
        vecs[4]  = '{32'h0000_0010, 32'h00A0_0093, 1'b0, 1};
        vecs[5]  = '{32'h0000_0410, 32'h1234_5678, 1'b0, 2};
        vecs[6]  = '{32'hFFFF_FFFC, 32'hDEAD_BEEF, 1'b0, 1};
        vecs[7]  = '{32'hFFFF_FFFC, 32'hDEAD_BEEF, 1'b1, 1};
        vecs[8]  = '{32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 2};
        vecs[9]  = '{32'hFFFF_FFFC, 32'hDEAD_BEEF, 1'b0, 1};
        vecs[10] = '{32'h0000_0012, 32'h00A0_0093, 1'b0, 1};

        rst = 1'b1; rdy = 1'b1; in_rollback = 1'b0; in_fetch_ena = 1'b0;
        in_fetch_addr = '0; in_mem_ok = 1'b0; in_mem_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ok", 32'(out_fetch_ok), 32'd0);
        chk("rst_mem_ena", 32'(out_mem_ena), 32'd0);
        chk("rst_inst", out_fetch_inst, 32'd0);
        chk("rst_mem_addr", out_mem_addr, 32'd0);
`ifdef ICACHE_STATS_EN
        chk("rst_hit_cnt", out_hit_cnt, 32'd0);
        chk("rst_miss_cnt", out_miss_cnt, 32'd0);
`endif

        for (int i = 0; i < 11; i++)
            fetch(vecs[i].addr, vecs[i].data, vecs[i].hit, vecs[i].lat);

        // Rollback while waiting, with a memory response in the same cycle: no fill, no return.
        @(negedge clk);
        in_fetch_ena = 1'b1; in_fetch_addr = 32'h0000_0020;
        @(negedge clk);
        in_fetch_ena = 1'b0;
        chk("rb_mem_ena", 32'(out_mem_ena), 32'd1);
        in_rollback = 1'b1; in_mem_ok = 1'b1; in_mem_data = 32'h5555_5555;
        @(negedge clk);
        in_rollback = 1'b0; in_mem_ok = 1'b0; in_mem_data = '0;
        chk("rb_ok", 32'(out_fetch_ok), 32'd0);
        chk("rb_mem_ena_clr", 32'(out_mem_ena), 32'd0);
        @(negedge clk);
        chk("rb_ok_after", 32'(out_fetch_ok), 32'd0);
        fetch(32'h0000_0020, 32'h2020_2020, 1'b0, 2);

        // Stray memory response while idle must not overwrite the line.
        @(negedge clk);
        in_mem_ok = 1'b1; in_mem_data = 32'hFFFF_0000;
        @(negedge clk);
        in_mem_ok = 1'b0; in_mem_data = '0;
        chk("stray_ok", 32'(out_fetch_ok), 32'd0);
        fetch(32'h0000_0020, 32'h2020_2020, 1'b1, 1);

        // Freeze with the hit pulse high.
        @(negedge clk);
        in_fetch_ena = 1'b1; in_fetch_addr = 32'h0000_0010;
        sb_q.push_back(32'h00A0_0093);
        @(negedge clk);
        in_fetch_ena = 1'b0;
        chk("frz_ok0", 32'(out_fetch_ok), 32'd1);
        pop_chk("frz_inst0");
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("frz_ok_hold", 32'(out_fetch_ok), 32'd1);
            chk("frz_inst_hold", out_fetch_inst, 32'h00A0_0093);
        end
        rdy = 1'b1;
        @(negedge clk);
        chk("frz_ok_clr", 32'(out_fetch_ok), 32'd0);

        // Back-to-back hits.
`ifdef ICACHE_STATS_EN
        h0 = out_hit_cnt;
`else
        h0 = '0;
`endif
        @(negedge clk);
        in_fetch_ena = 1'b1; in_fetch_addr = 32'h0000_0010;
        sb_q.push_back(32'h00A0_0093);
        @(negedge clk);
        in_fetch_addr = 32'h0000_0014;
        sb_q.push_back(32'h1111_1111);
        chk("b2b_ok0", 32'(out_fetch_ok), 32'd1);
        pop_chk("b2b_inst0");
        @(negedge clk);
        in_fetch_ena = 1'b0;
        chk("b2b_ok1", 32'(out_fetch_ok), 32'd1);
        pop_chk("b2b_inst1");
        @(negedge clk);
        chk("b2b_ok_clr", 32'(out_fetch_ok), 32'd0);
        chk("b2b_mem_ena", 32'(out_mem_ena), 32'd0);
`ifdef ICACHE_STATS_EN
        chk("b2b_hit_cnt", out_hit_cnt, h0 + 32'd2);
`endif

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
